parking_slot_billing_ctrl: RTL and testbench

//  Sequential front-end to the 4-slot parking lot allocator and fee datapath.
//  - Keeps a 4-bit hour clock, grants free slots with lowest-index priority
//    and records each vehicle's entry time.
//  - On departure, computes duration = exit - entry (mod 16) and fee = duration * RATE.
//  - Presents the fee to the downstream payment stage over a valid/ready handshake.

---
 rtl/parking_slot_billing_ctrl_if.sv | 25 ++
 rtl/parking_slot_billing_ctrl.sv | 81 ++++++++
 tb/tb_parking_slot_billing_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/parking_slot_billing_ctrl_if.sv
// parking_slot_billing_ctrl_if: handshake bundle between the parking lot front-end and its users.
//  arrive_valid/arrive_ready/grant_slot : slot request and one-hot grant
//  depart_valid/depart_slot/depart_ready/depart_err : departure request and empty-slot error
//  fee_valid/fee_ready/fee/duration : billed fee towards the payment stage
interface parking_slot_billing_ctrl_if;
  logic       arrive_valid;
  logic       arrive_ready;
  logic [3:0] grant_slot;
  logic       depart_valid;
  logic [1:0] depart_slot;
  logic       depart_ready;
  logic       depart_err;
  logic       fee_valid;
  logic       fee_ready;
  logic [7:0] fee;
  logic [3:0] duration;
  modport slave (
    input  arrive_valid, depart_valid, depart_slot, fee_ready,
    output arrive_ready, grant_slot, depart_ready, depart_err, fee_valid, fee, duration
  );
  modport master (
    output arrive_valid, depart_valid, depart_slot, fee_ready,
    input  arrive_ready, grant_slot, depart_ready, depart_err, fee_valid, fee, duration
  );
endinterface

// File: rtl/parking_slot_billing_ctrl.sv
// parking_slot_billing_ctrl: 4-slot parking allocator with hour clock and per-stay fee billing.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : arrival / departure / fee handshakes (slave side)
//  occupancy  : bit i high = slot i occupied
//  full       : all four slots occupied
//  cur_time   : current hour counter
module parking_slot_billing_ctrl #(
  parameter int RATE           = 2,
  parameter int TICKS_PER_HOUR = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  parking_slot_billing_ctrl_if.slave   bus,
  output logic [3:0]                   occupancy,
  output logic                         full,
  output logic [3:0]                   cur_time
);
  localparam int TW = $clog2(TICKS_PER_HOUR);
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
  state_t        state, state_n;
  logic [TW-1:0] tick;
  logic [3:0]    entry [4];
  logic [3:0]    grant, dep_mask, exit_q, ent_q, d, dur_c, dur_q;
  logic [7:0]    fee_q;
  logic          arrive_fire, depart_take, depart_bad, err_q;
  always_comb begin
    // lowest zero bit of occupancy, one-hot; zero when full
    grant       = ~occupancy & (occupancy + 4'd1);
    full        = &occupancy;
    arrive_fire = bus.arrive_valid && !full;
    depart_take = state == IDLE && bus.depart_valid && occupancy[bus.depart_slot];
    depart_bad  = state == IDLE && bus.depart_valid && !occupancy[bus.depart_slot];
    dep_mask    = depart_take ? 4'b0001 << bus.depart_slot : 4'b0000;
    d           = exit_q - ent_q;
    // same-hour departure is still billed one hour
    dur_c       = (d == 4'd0) ? 4'd1 : d;
    state_n     = (state == IDLE) ? (depart_take ? CALC : IDLE) :
                  (state == CALC) ? HOLD : (bus.fee_ready ? IDLE : HOLD);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick      <= '0;
      cur_time  <= '0;
      occupancy <= '0;
      for (int i = 0; i < 4; i++) entry[i] <= '0;
      exit_q    <= '0;
      ent_q     <= '0;
      fee_q     <= '0;
      dur_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      if (tick == TW'(TICKS_PER_HOUR - 1)) begin
        tick     <= '0;
        cur_time <= cur_time + 4'd1;
      end else tick <= tick + 1'b1;
      // grant never overlaps the departing slot: one is free, the other occupied
      occupancy <= (occupancy | (arrive_fire ? grant : 4'b0000)) & ~dep_mask;
      for (int i = 0; i < 4; i++) if (arrive_fire && grant[i]) entry[i] <= cur_time;
      // entry is captured at departure so a re-grant of the freed slot during CALC is harmless
      if (depart_take) begin
        exit_q <= cur_time;
        ent_q  <= entry[bus.depart_slot];
      end
      if (state == CALC) begin
        dur_q <= dur_c;
        fee_q <= {4'd0, dur_c} * 8'(RATE);
      end
      err_q <= depart_bad;
    end
  end
  assign bus.arrive_ready = !full;
  assign bus.grant_slot   = grant;
  assign bus.depart_ready = state == IDLE;
  assign bus.depart_err   = err_q;
  assign bus.fee_valid    = state == HOLD;
  assign bus.fee          = fee_q;
  assign bus.duration     = dur_q;
endmodule

// File: tb/tb_parking_slot_billing_ctrl.sv
// tb_parking_slot_billing_ctrl: directed stimulus with a fee scoreboard for parking_slot_billing_ctrl.
module tb_parking_slot_billing_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] occupancy, cur_time;
  logic full;
  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q [$];
  parking_slot_billing_ctrl_if bus ();
  parking_slot_billing_ctrl #(.RATE(2), .TICKS_PER_HOUR(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .occupancy(occupancy), .full(full), .cur_time(cur_time)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask
  // first falling edge of hour h
  task automatic to_hour(input logic [3:0] h);
    logic [3:0] p;
    int n;
    p = cur_time;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (cur_time == h && p != h) break;
      p = cur_time;
      if (n > 300) begin
        chk("to_hour_timeout", int'(cur_time), int'(h));
        break;
      end
    end
  endtask
  task automatic depart(input logic [1:0] s);
    bus.depart_valid = 1'b1;
    bus.depart_slot  = s;
  endtask
  // scoreboard monitor: compares every fee handed over to the payment stage
  always begin
    logic [11:0] e;
    @(negedge clk);
    #2;
    if (rst_n && bus.fee_valid && bus.fee_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected fee got=%0d expected=none", bus.fee);
      end else begin
        e = exp_q.pop_front();
        chk("sb_fee", int'(bus.fee), int'(e[11:4]));
        chk("sb_duration", int'(bus.duration), int'(e[3:0]));
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    bus.arrive_valid = 1'b0;
    bus.depart_valid = 1'b0;
    bus.depart_slot  = 2'd0;
    bus.fee_ready    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_fee_valid", bus.fee_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_cur_time", cur_time, 0);
    chk("rst_depart_err", bus.depart_err, 0);
    chk("rst_fee", bus.fee, 0);
    chk("rst_duration", bus.duration, 0);
    chk("rst_arrive_ready", bus.arrive_ready, 1);
    chk("rst_depart_ready", bus.depart_ready, 1);
    chk("rst_grant", bus.grant_slot, 4'b0001);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    chk("time_before_wrap", cur_time, 0);
    @(negedge clk);
    chk("time_after_wrap", cur_time, 1);
    // four consecutive arrivals at hour 3
    to_hour(3);
    bus.arrive_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("grant_seq", bus.grant_slot, 1 << i);
      @(negedge clk);
    end
    chk("full", full, 1);
    chk("arrive_ready_full", bus.arrive_ready, 0);
    chk("grant_full", bus.grant_slot, 0);
    @(negedge clk);
    chk("occ_full_held", occupancy, 4'b1111);
    bus.arrive_valid = 1'b0;
    // slot 1: entry 3, exit 8, fee held for five cycles
    to_hour(8);
    bus.fee_ready = 1'b0;
    depart(2'd1);
    chk("depart_ready_idle", bus.depart_ready, 1);
    exp_q.push_back({8'd10, 4'd5});
    @(negedge clk);
    bus.depart_valid = 1'b0;
    chk("calc_fee_valid", bus.fee_valid, 0);
    chk("calc_occupancy", occupancy, 4'b1101);
    chk("calc_depart_ready", bus.depart_ready, 0);
    @(negedge clk);
    chk("latency_fee_valid", bus.fee_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_fee_valid", bus.fee_valid, 1);
      chk("hold_fee", bus.fee, 10);
      chk("hold_depart_ready", bus.depart_ready, 0);
    end
    bus.fee_ready = 1'b1;
    @(negedge clk);
    chk("release_fee_valid", bus.fee_valid, 0);
    chk("release_depart_ready", bus.depart_ready, 1);
    // wrap-around: entry 14, exit 2
    to_hour(14);
    bus.arrive_valid = 1'b1;
    chk("grant_freed", bus.grant_slot, 4'b0010);
    @(negedge clk);
    bus.arrive_valid = 1'b0;
    chk("occ_refill", occupancy, 4'b1111);
    to_hour(2);
    depart(2'd1);
    exp_q.push_back({8'd8, 4'd4});
    @(negedge clk);
    bus.depart_valid = 1'b0;
    @(negedge clk);
    chk("wrap_fee_valid", bus.fee_valid, 1);
    @(negedge clk);
    chk("wrap_fee_drop", bus.fee_valid, 0);
    // same-hour stay billed as one hour
    to_hour(4);
    bus.arrive_valid = 1'b1;
    chk("grant_same_hour", bus.grant_slot, 4'b0010);
    @(negedge clk);
    bus.arrive_valid = 1'b0;
    depart(2'd1);
    exp_q.push_back({8'd2, 4'd1});
    repeat (4) @(negedge clk);
    bus.depart_valid = 1'b0;
    chk("same_hour_idle", bus.depart_ready, 1);
    // departure while full with an arrival waiting: freed slot granted a cycle later
    to_hour(5);
    bus.arrive_valid = 1'b1;
    @(negedge clk);
    chk("sim_occ_full", occupancy, 4'b1111);
    chk("sim_arrive_blocked", bus.arrive_ready, 0);
    depart(2'd0);
    exp_q.push_back({8'd4, 4'd2});
    @(negedge clk);
    bus.depart_valid = 1'b0;
    chk("sim_occ_freed", occupancy, 4'b1110);
    chk("sim_grant_next", bus.grant_slot, 4'b0001);
    @(negedge clk);
    bus.arrive_valid = 1'b0;
    chk("sim_occ_regrant", occupancy, 4'b1111);
    @(negedge clk);
    // slot 2 billed, then departing it again is an error
    to_hour(7);
    depart(2'd2);
    exp_q.push_back({8'd8, 4'd4});
    @(negedge clk);
    bus.depart_valid = 1'b0;
    repeat (2) @(negedge clk);
    depart(2'd2);
    chk("err_depart_ready", bus.depart_ready, 1);
    @(negedge clk);
    bus.depart_valid = 1'b0;
    chk("err_pulse", bus.depart_err, 1);
    chk("err_occupancy", occupancy, 4'b1011);
    chk("err_fee_valid", bus.fee_valid, 0);
    chk("err_stay_idle", bus.depart_ready, 1);
    @(negedge clk);
    chk("err_pulse_end", bus.depart_err, 0);
    chk("err_no_fee", bus.fee_valid, 0);
    // reset while holding a fee: entry 3, exit 9
    to_hour(9);
    bus.fee_ready = 1'b0;
    depart(2'd3);
    @(negedge clk);
    bus.depart_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_fee_valid", bus.fee_valid, 1);
    chk("pre_rst_fee", bus.fee, 12);
    chk("pre_rst_duration", bus.duration, 6);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_fee_valid", bus.fee_valid, 0);
    chk("midrst_occupancy", occupancy, 0);
    chk("midrst_cur_time", cur_time, 0);
    chk("midrst_full", full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.fee_ready = 1'b1;
    bus.arrive_valid = 1'b1;
    chk("post_rst_grant", bus.grant_slot, 4'b0001);
    @(negedge clk);
    bus.arrive_valid = 1'b0;
    chk("post_rst_occ", occupancy, 4'b0001);
    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
